// File: rtl/pcs_out_32b.sv
// 10GBASE-R transmit PCS, 32-bit XGMII in, 32-bit PMA out.
// Pairs words into columns, 64b/66b encodes, scrambles and gearboxes 66 -> 32 bits.
package pcs_out_32b_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic        ena;
  } xgmii32_t;
endpackage

module pcs_out_32b
  import pcs_out_32b_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  xgmii32_t    xgmii_tx,
  output logic        xgmii_tx_rdy,
  output logic [31:0] pma_data
);

  function automatic logic idle_or_err(input logic [7:0] b);
    return (b == 8'h07) || (b == 8'hFE);
  endfunction

  function automatic logic [6:0] ctl_code(input logic [7:0] b);
    return (b == 8'h07) ? 7'h00 : 7'h1E;
  endfunction

  function automatic logic [7:0] term_type(input logic [2:0] n);
    case (n)
      3'd0:    return 8'h87;
      3'd1:    return 8'h99;
      3'd2:    return 8'hAA;
      3'd3:    return 8'hB4;
      3'd4:    return 8'hCC;
      3'd5:    return 8'hD2;
      3'd6:    return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  // block[1:0] is the sync header, block[65:2] the payload (payload bit 0 = block[2])
  function automatic logic [65:0] encode(input logic [63:0] d, input logic [7:0] c);
    logic [63:0] p;
    logic        all_ctl;
    logic        is_term;
    logic        m;
    logic [2:0]  tn;
    p       = '0;
    all_ctl = 1'b1;
    is_term = 1'b0;
    tn      = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!c[i] || !idle_or_err(d[8*i +: 8])) all_ctl = 1'b0;
    for (int n = 0; n < 8; n++) begin
      m = c[n] && (d[8*n +: 8] == 8'hFD);
      for (int i = 0; i < 8; i++) begin
        if (i < n && c[i]) m = 1'b0;
        if (i > n && !(c[i] && idle_or_err(d[8*i +: 8]))) m = 1'b0;
      end
      if (m) begin
        is_term = 1'b1;
        tn      = 3'(n);
      end
    end
    if (c == 8'h00) begin
      return {d, 2'b10};
    end else if (all_ctl) begin
      p[7:0] = 8'h1E;
      for (int j = 0; j < 8; j++) p[8+7*j +: 7] = ctl_code(d[8*j +: 8]);
    end else if (c == 8'h01 && d[7:0] == 8'hFB) begin
      p = {d[63:8], 8'h78};
    end else if (c == 8'h1F && d[39:32] == 8'hFB && d[31:0] == 32'h07070707) begin
      p = {d[63:40], 4'h0, 28'h0, 8'h33};
    end else if (is_term) begin
      p[7:0] = term_type(tn);
      for (int i = 0; i < 8; i++) begin
        if (i < 32'(tn)) p[8+8*i +: 8] = d[8*i +: 8];
        if (i > 32'(tn)) p[8+7*i +: 7] = ctl_code(d[8*i +: 8]);
      end
    end else begin
      p[7:0] = 8'h1E;
      for (int j = 0; j < 8; j++) p[8+7*j +: 7] = 7'h1E;
    end
    return {p, 2'b01};
  endfunction

  logic [5:0]   seq;
  logic         started;
  logic         half;
  logic [31:0]  lo_d;
  logic [3:0]   lo_c;
  logic [63:0]  col_d;
  logic [7:0]   col_c;
  logic         col_vld;
  logic [65:0]  enc_q;
  logic         enc_vld;
  logic [57:0]  scr_s;
  logic [57:0]  scr_st;
  logic [63:0]  scr_pay;
  logic [65:0]  scr_q;
  logic         scr_vld;
  logic [127:0] gb_buf;
  logic [127:0] gb_ext;
  logic [7:0]   gb_cnt;
  logic [7:0]   gb_cnt_ext;
  logic         gb_on;
  logic [31:0]  w_d;
  logic [3:0]   w_c;

  assign xgmii_tx_rdy = started && (seq != 6'd32);
  assign w_d = xgmii_tx.ena ? xgmii_tx.data : 32'h07070707;
  assign w_c = xgmii_tx.ena ? xgmii_tx.ctrl : 4'hF;

  always_comb begin
    scr_st  = scr_s;
    scr_pay = '0;
    for (int i = 0; i < 64; i++) begin
      scr_pay[i] = enc_q[2+i] ^ scr_st[38] ^ scr_st[57];
      scr_st     = {scr_st[56:0], scr_pay[i]};
    end
  end

  // new block lands directly above the bits still waiting in the gearbox
  always_comb begin
    gb_ext     = gb_buf;
    gb_cnt_ext = gb_cnt;
    if (scr_vld) begin
      gb_ext     = gb_buf | ({62'd0, scr_q} << gb_cnt);
      gb_cnt_ext = gb_cnt + 8'd66;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= '0;
      started  <= 1'b0;
      half     <= 1'b0;
      lo_d     <= '0;
      lo_c     <= '0;
      col_d    <= '0;
      col_c    <= '0;
      col_vld  <= 1'b0;
      enc_q    <= '0;
      enc_vld  <= 1'b0;
      scr_s    <= '1;
      scr_q    <= '0;
      scr_vld  <= 1'b0;
      gb_buf   <= '0;
      gb_cnt   <= '0;
      gb_on    <= 1'b0;
      pma_data <= '0;
    end else begin
      started <= 1'b1;
      if (started) seq <= (seq == 6'd32) ? 6'd0 : seq + 6'd1;

      col_vld <= 1'b0;
      if (xgmii_tx_rdy) begin
        if (!half) begin
          lo_d <= w_d;
          lo_c <= w_c;
          half <= 1'b1;
        end else begin
          col_d   <= {w_d, lo_d};
          col_c   <= {w_c, lo_c};
          half    <= 1'b0;
          col_vld <= 1'b1;
        end
      end

      enc_vld <= col_vld;
      if (col_vld) enc_q <= encode(col_d, col_c);

      scr_vld <= enc_vld;
      if (enc_vld) begin
        scr_q <= {scr_pay, enc_q[1:0]};
        scr_s <= scr_st;
      end

      if (scr_vld || gb_on) begin
        gb_on    <= 1'b1;
        pma_data <= gb_ext[31:0];
        gb_buf   <= gb_ext >> 32;
        gb_cnt   <= gb_cnt_ext - 8'd32;
      end
    end
  end

endmodule

// File: tb/tb_pcs_out_32b.sv
// Bench for pcs_out_32b: drives columns, descrambles the PMA stream and
// compares each recovered 66-bit block against a queue of expected blocks.
module tb_pcs_out_32b;
  import pcs_out_32b_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  xgmii32_t    xgmii_tx = '0;
  logic        xgmii_tx_rdy;
  logic [31:0] pma_data;

  int n_assert = 0;
  int n_fail = 0;

  logic [65:0] exp_q[$];
  int          tag_q[$];

  pcs_out_32b dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .xgmii_tx     (xgmii_tx),
    .xgmii_tx_rdy (xgmii_tx_rdy),
    .pma_data     (pma_data)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] ctl_blk(input logic [63:0] p);
    return {p, 2'b01};
  endfunction

  function automatic logic [65:0] dat_blk(input logic [63:0] d);
    return {d, 2'b10};
  endfunction

  // ---------------- monitor: descramble, frame, compare ----------------
  int          rel_cnt = 0;
  bit          bq[$];
  logic [57:0] ds = '1;
  logic [65:0] mon_blk;
  logic [65:0] mon_exp;
  int          mon_tag;
  bit          mon_b;
  logic        exp_rdy;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rel_cnt = 0;
      bq.delete();
      ds = '1;
      n_assert++;
      assert (pma_data === 32'h0) else begin
        n_fail++;
        $error("FAIL rst_pma got %h exp %h", pma_data, 32'h0);
      end
      n_assert++;
      assert (xgmii_tx_rdy === 1'b0) else begin
        n_fail++;
        $error("FAIL rst_rdy got %b exp 0", xgmii_tx_rdy);
      end
    end else begin
      rel_cnt++;
      exp_rdy = (((rel_cnt - 1) % 33) != 32);
      n_assert++;
      assert (xgmii_tx_rdy === exp_rdy) else begin
        n_fail++;
        $error("FAIL rdy cyc=%0d got %b exp %b", rel_cnt, xgmii_tx_rdy, exp_rdy);
      end
      if (rel_cnt < 6) begin
        n_assert++;
        assert (pma_data === 32'h0) else begin
          n_fail++;
          $error("FAIL pre_pma cyc=%0d got %h exp %h", rel_cnt, pma_data, 32'h0);
        end
      end else begin
        for (int i = 0; i < 32; i++) bq.push_back(pma_data[i]);
        while (bq.size() >= 66) begin
          mon_blk[0] = bq.pop_front();
          mon_blk[1] = bq.pop_front();
          for (int i = 0; i < 64; i++) begin
            mon_b = bq.pop_front();
            mon_blk[2+i] = mon_b ^ ds[38] ^ ds[57];
            ds = {ds[56:0], mon_b};
          end
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            n_assert++;
            assert (mon_blk === mon_exp) else begin
              n_fail++;
              $error("FAIL blk tag=%0d got %h exp %h", mon_tag, mon_blk, mon_exp);
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_word(input logic [31:0] d, input logic [3:0] c, input logic e);
    logic r;
    int   guard;
    xgmii_tx.data = d;
    xgmii_tx.ctrl = c;
    xgmii_tx.ena  = e;
    guard = 0;
    do begin
      r = xgmii_tx_rdy;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end while (!r && guard < 4);
    if (!r) begin
      n_assert++;
      n_fail++;
      $error("FAIL rdy_timeout got 0 exp 1");
    end
  endtask

  task automatic send_col(input logic [63:0] d, input logic [7:0] c, input logic e,
                          input bit push, input logic [65:0] exp, input int tag);
    if (push) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    send_word(d[31:0], c[3:0], e);
    send_word(d[63:32], c[7:4], e);
  endtask

  task automatic send_frame(input int tag);
    logic [63:0] d;
    d = 64'hD5555555_555555FB;
    send_col(d, 8'h01, 1'b1, 1'b1, ctl_blk({d[63:8], 8'h78}), tag);
    for (int m = 0; m < 7; m++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'((8*m + i) * 37 + 11);
      send_col(d, 8'h00, 1'b1, 1'b1, dat_blk(d), tag + 1);
    end
    for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'((56 + i) * 37 + 11);
    d[63:32] = 32'h070707FD;
    send_col(d, 8'hF0, 1'b1, 1'b1, ctl_blk({24'h0, d[31:0], 8'hCC}), tag + 2);
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] cd;
  logic [7:0]  cc;
  logic [63:0] ep;
  logic [7:0]  ttypes [8];
  logic [31:0] inc_lo;
  logic [31:0] inc_hi;

  initial begin
    ttypes[0] = 8'h87; ttypes[1] = 8'h99; ttypes[2] = 8'hAA; ttypes[3] = 8'hB4;
    ttypes[4] = 8'hCC; ttypes[5] = 8'hD2; ttypes[6] = 8'hE1; ttypes[7] = 8'hFF;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle with ena low: substituted idle words, roughly 500 cycles
    for (int k = 0; k < 242; k++)
      send_col(64'h0, 8'h00, 1'b0, 1'b1, ctl_blk(64'h1E), 1);

    send_frame(2);

    // start in lane 4
    cd = {8'hC3, 8'hB2, 8'hA1, 8'hFB, 32'h07070707};
    send_col(cd, 8'h1F, 1'b1, 1'b1, ctl_blk({cd[63:40], 4'h0, 28'h0, 8'h33}), 5);

    // terminate in every lane
    for (int n = 0; n < 8; n++) begin
      cd = '0; cc = '0; ep = '0;
      for (int i = 0; i < 8; i++) begin
        if (i < n) begin
          cd[8*i +: 8] = 8'hA0 + 8'(i);
          ep[8+8*i +: 8] = 8'hA0 + 8'(i);
        end else if (i == n) begin
          cd[8*i +: 8] = 8'hFD;
          cc[i] = 1'b1;
        end else begin
          cd[8*i +: 8] = 8'h07;
          cc[i] = 1'b1;
        end
      end
      ep[7:0] = ttypes[n];
      send_col(cd, cc, 1'b1, 1'b1, ctl_blk(ep), 10 + n);
    end

    // start character in lane 2 is invalid -> error block, then recovery
    ep = '0;
    ep[7:0] = 8'h1E;
    for (int j = 0; j < 8; j++) ep[8+7*j +: 7] = 7'h1E;
    send_col(64'h07070707_07FB0707, 8'hFF, 1'b1, 1'b1, ctl_blk(ep), 20);
    send_col(64'h01234567_89ABCDEF, 8'h00, 1'b1, 1'b1, dat_blk(64'h01234567_89ABCDEF), 21);

    // continuous incrementing words across several stall cycles
    for (int k = 0; k < 40; k++) begin
      inc_lo = 32'h1000_0000 + 32'(2 * k);
      inc_hi = inc_lo + 32'd1;
      send_col({inc_hi, inc_lo}, 8'h00, 1'b1, 1'b1, dat_blk({inc_hi, inc_lo}), 30);
    end

    // reset in the middle of a frame
    cd = 64'hD5555555_555555FB;
    send_col(cd, 8'h01, 1'b1, 1'b1, ctl_blk({cd[63:8], 8'h78}), 40);
    send_col(64'h11223344_55667788, 8'h00, 1'b1, 1'b1, dat_blk(64'h11223344_55667788), 41);
    rst_n = 1'b0;
    exp_q.delete();
    tag_q.delete();
    xgmii_tx = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    send_frame(50);
    for (int k = 0; k < 3; k++)
      send_col(64'h0, 8'h00, 1'b0, 1'b1, ctl_blk(64'h1E), 60);

    // keep the DUT fed until every expected block has been seen
    for (int g = 0; g < 20 && exp_q.size() != 0; g++)
      send_col(64'h0, 8'h00, 1'b0, 1'b0, '0, 0);
    n_assert++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL drain got %0d exp 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
